// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM state encoding and the default operand width. The ALU controller
// imports the same op codes when it decodes funct fields.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

    // Operations that start the iterative engine.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Single-cycle register moves into HI or LO.
    function automatic logic is_move_op(input logic [2:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate. Used both to take operand
// magnitudes at accept time and to restore result signs at the end.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle on a single 2*WIDTH+1-bit shift register: shift-add
// for multiply, restoring shift-subtract for divide. Signed operations run
// on magnitudes and get their signs restored in the FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    // acc_q layout: [2W:W] partial product / remainder, [W-1:0] multiplier / quotient
    logic [2*WIDTH:0] acc_q;
    logic [WIDTH-1:0] opb_q;
    logic             is_div_q;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic             dz_q;

    logic accept;
    logic move_accept;
    logic fix_write;

    // Operand decode at the accept edge
    logic             signed_op;
    logic             div_op;
    logic             b_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] mag_a;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign div_op    = (op == OP_DIV)  || (op == OP_DIVU);
    assign b_zero    = (b == '0);

    muldiv_signfix #(.W(WIDTH)) u_abs_a (.x(a), .neg(signed_op & a[WIDTH-1]), .y(abs_a));
    muldiv_signfix #(.W(WIDTH)) u_abs_b (.x(b), .neg(signed_op & b[WIDTH-1]), .y(abs_b));

    // Divide by zero keeps the raw dividend so the remainder comes out as a unchanged.
    assign mag_a = (div_op && b_zero) ? a : abs_a;

    // One iteration of each algorithm
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] mul_next;
    logic [2*WIDTH:0] div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH:0] div_next;
    logic [2*WIDTH:0] acc_step;

    assign mul_sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next  = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    assign div_shift = {acc_q[2*WIDTH-1:0], 1'b0};
    assign div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, opb_q};
    assign div_next  = div_diff[WIDTH] ? div_shift
                                       : {div_diff, div_shift[WIDTH-1:1], 1'b1};
    assign acc_step  = is_div_q ? div_next : mul_next;

    // Sign correction of the finished result
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (.x(acc_q[2*WIDTH-1:0]),     .neg(neg_lo_q), .y(prod_fix));
    muldiv_signfix #(.W(WIDTH))   u_fix_quo  (.x(acc_q[WIDTH-1:0]),       .neg(neg_lo_q), .y(quo_fix));
    muldiv_signfix #(.W(WIDTH))   u_fix_rem  (.x(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_hi_q), .y(rem_fix));

    assign busy = (state_q != ST_IDLE);

    // Next-state and per-cycle control strobes; flush blocks any accept and any write-back
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        move_accept = 1'b0;
        fix_write   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (is_arith_op(op)) begin
                        accept  = 1'b1;
                        state_d = ST_RUN;
                    end else if (is_move_op(op)) begin
                        move_accept = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d   = ST_IDLE;
                fix_write = !flush;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state, iteration counter and the architectural HI/LO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state_q  <= state_d;
            done     <= fix_write;
            div_zero <= fix_write & dz_q;
            if (accept) begin
                cnt_q <= CNT_W'(WIDTH);
            end else if (state_q == ST_RUN) begin
                cnt_q <= flush ? '0 : cnt_q - CNT_W'(1);
            end
            if (fix_write) begin
                if (is_div_q) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    {hi, lo} <= prod_fix;
                end
            end else if (move_accept) begin
                if (op == OP_MTHI) begin
                    hi <= a;
                end else begin
                    lo <= a;
                end
            end
        end
    end

    // Datapath: load magnitudes and result signs on accept, then iterate while running
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_q    <= {{(WIDTH+1){1'b0}}, mag_a};
            opb_q    <= abs_b;
            is_div_q <= div_op;
            dz_q     <= div_op & b_zero;
            neg_lo_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]) & !(div_op & b_zero);
            neg_hi_q <= div_op ? (signed_op & a[WIDTH-1] & !b_zero)
                               : (signed_op & (a[WIDTH-1] ^ b[WIDTH-1]));
        end else if (state_q == ST_RUN) begin
            acc_q <= acc_step;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table of directed vectors, a few
// model-checked random operations and hand-written multi-cycle sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference behaviour using plain integer arithmetic
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output exp_t e);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sx;
        int                 sy;
        e.hi = '0; e.lo = '0; e.dz = 1'b0;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            OP_MULT: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                {e.hi, e.lo} = sp;
            end
            OP_MULTU: begin
                up = {32'b0, x} * {32'b0, y};
                {e.hi, e.lo} = up;
            end
            OP_DIV: begin
                if (y == 0) begin
                    e.hi = x; e.lo = '1; e.dz = 1'b1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.hi = '0; e.lo = x;
                end else begin
                    e.lo = 32'(sx / sy);
                    e.hi = 32'(sx % sy);
                end
            end
            OP_DIVU: begin
                if (y == 0) begin
                    e.hi = x; e.lo = '1; e.dz = 1'b1;
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
            default: ;
        endcase
    endtask

    task automatic push_exp(input logic [W-1:0] h, input logic [W-1:0] l, input logic dz);
        exp_t e;
        e.hi = h; e.lo = l; e.dz = dz;
        sb_q.push_back(e);
        exp_hi = h;
        exp_lo = l;
    endtask

    // Drive one request for a single accepting edge; returns #1 after that edge
    task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges from the accept edge until done is seen, and busy cycles on the way
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        if (!done) chk("done_timeout", done, 1);
    endtask

    // Scoreboard: every done pops one expected result
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("done_with_empty_scoreboard", done, 0);
            end else begin
                e = sb_q.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_zero", div_zero, e.dz);
            end
        end else if (div_zero) begin
            chk("div_zero_without_done", div_zero, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    vec_t tbl[12];
    exp_t me;
    int   lat;
    int   bc;

    initial begin
        tbl[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        tbl[1]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[2]  = '{OP_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         1'b0};
        tbl[3]  = '{OP_DIVU,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        tbl[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
        tbl[5]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0};
        tbl[6]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0};
        tbl[7]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        tbl[8]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0,         1'b0};
        tbl[9]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 1'b0};
        tbl[10] = '{OP_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
        tbl[11] = '{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,        1'b0};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_div_zero", div_zero, 0);

        // Release reset and request in the same cycle: first edge must accept
        @(negedge clk);
        rst = 1'b0; start = 1'b1; op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        push_exp(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept_after_reset", busy, 1);
        wait_done(lat, bc);
        chk("multu_latency", lat, W + 1);
        chk("multu_busy_cycles", bc, W + 1);
        @(posedge clk);
        #1;
        chk("done_single_cycle", done, 0);
        chk("busy_after_done", busy, 0);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            push_exp(tbl[i].hi, tbl[i].lo, tbl[i].dz);
            start_op(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_done(lat, bc);
            chk("table_latency", lat, W + 1);
        end

        // Random operations against the integer model
        for (int i = 0; i < 8; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (i == 5) rb = '0;
            model(ro, ra, rb, me);
            push_exp(me.hi, me.lo, me.dz);
            start_op(ro, ra, rb);
            wait_done(lat, bc);
            chk("random_latency", lat, W + 1);
        end

        // MTLO presented at cycle 10 of a MULT is ignored
        model(OP_MULT, 32'h0000_1234, 32'h0000_5678, me);
        push_exp(me.hi, me.lo, me.dz);
        start_op(OP_MULT, 32'h0000_1234, 32'h0000_5678);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = OP_MTLO; a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_during_ignored_mtlo", busy, 1);
        wait_done(lat, bc);
        chk("mult_after_mtlo_latency", lat, W + 1 - 10);

        // Register moves in IDLE
        start_op(OP_MTLO, 32'h5A5A_1234, 32'd0);
        chk("mtlo_lo", lo, 32'h5A5A_1234);
        chk("mtlo_hi_untouched", hi, exp_hi);
        exp_lo = 32'h5A5A_1234;
        start_op(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
        chk("mthi_hi", hi, 32'hA5A5_A5A5);
        chk("mthi_lo_untouched", lo, exp_lo);
        chk("mthi_busy", busy, 0);
        chk("mthi_done", done, 0);
        exp_hi = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        chk("mthi_done_later", done, 0);

        // Flush at RUN cycle 5: back to IDLE, HI/LO unchanged, no done
        start_op(OP_MULT, 32'd3, 32'd4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_hi_kept", hi, exp_hi);
        chk("flush_lo_kept", lo, exp_lo);

        // Undefined op code is ignored
        start_op(3'd6, 32'h1111_1111, 32'h2222_2222);
        chk("undef_op_busy", busy, 0);
        start_op(3'd7, 32'h1111_1111, 32'h2222_2222);
        chk("undef_op7_busy", busy, 0);
        chk("undef_op_hi", hi, exp_hi);
        chk("undef_op_lo", lo, exp_lo);

        // Flush in IDLE wins over a same-cycle start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", busy, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_idle_hi", hi, exp_hi);

        // Reset at RUN cycle 12 clears everything immediately
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrun_rst_hi", hi, 0);
        chk("midrun_rst_lo", lo, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        repeat (40) @(posedge clk);
        #1;
        chk("after_rst_busy", busy, 0);
        chk("after_rst_lo", lo, 0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
